// File: rtl/sd_wb_dma_master.sv
// Wishbone DMA master for the SD data path: moves a byte-aligned transfer between memory
// and the SD FIFOs as word-aligned single Wishbone cycles, driving sd_wb_sel_ctrl.
module sd_wb_dma_master #(
    parameter int unsigned BLKSIZE_W = 12,
    parameter int unsigned BLKCNT_W  = 16,
    parameter int unsigned XW        = BLKSIZE_W + BLKCNT_W
) (
    input  logic          wb_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic          abort,
    input  logic [31:0]   base_adr_i,
    input  logic [XW-1:0] xfersize_i,
    output logic [31:0]   sel_base_adr_o,
    output logic [XW-1:0] sel_xfersize_o,
    output logic          sel_ena_o,
    output logic [31:0]   wbm_adr_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [31:0]   wbm_dat_o,
    input  logic [31:0]   wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic [31:0]   rd_data_i,
    input  logic          rd_empty_i,
    output logic          rd_en_o,
    output logic [31:0]   wr_data_o,
    input  logic          wr_full_i,
    output logic          wr_en_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StWait, StLoad, StBus, StDone, StFail
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [XW:0]   cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [31:0]   sel_base_q, sel_base_d;
    logic [XW-1:0] sel_size_q, sel_size_d;
    logic [31:0]   dat_q, dat_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic          abort_q, abort_d;

    logic [XW:0]   span;
    logic [XW:0]   start_cnt;
    logic          beat_ack;
    logic          beat_err;

    // Word count covering the leading misalignment plus rounding up the tail.
    assign span      = {{(XW-1){1'b0}}, base_adr_i[1:0]} + {1'b0, xfersize_i} + (XW+1)'(3);
    assign start_cnt = {2'b00, span[XW:2]};

    assign beat_err = (state_q == StBus) && wbm_err_i;
    assign beat_ack = (state_q == StBus) && wbm_ack_i && !wbm_err_i;

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            adr_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            sel_base_q <= '0;
            sel_size_q <= '0;
            dat_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            sel_base_q <= sel_base_d;
            sel_size_q <= sel_size_d;
            dat_q      <= dat_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sel_base_d = sel_base_q;
        sel_size_d = sel_size_q;
        dat_d      = dat_q;
        abort_d    = abort_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSetup;
                    adr_d      = {base_adr_i[31:2], 2'b00};
                    cnt_d      = start_cnt;
                    dir_d      = dir;
                    sel_base_d = base_adr_i;
                    sel_size_d = xfersize_i;
                    abort_d    = 1'b0;
                end
            end
            StSetup: begin
                if (abort)              state_d = StIdle;
                else if (cnt_q == '0)   state_d = StDone;
                else                    state_d = StWait;
            end
            StWait: begin
                if (abort)                     state_d = StIdle;
                else if (dir_q && !wr_full_i)  state_d = StBus;
                else if (!dir_q && !rd_empty_i) state_d = StLoad;
            end
            StLoad: begin
                dat_d   = rd_data_i;
                state_d = abort ? StIdle : StBus;
            end
            StBus: begin
                // An abort during a beat is remembered until the beat terminates.
                if (abort) abort_d = 1'b1;
                if (beat_err) begin
                    state_d = StFail;
                end else if (beat_ack) begin
                    adr_d = adr_q + 32'd4;
                    cnt_d = cnt_q - (XW+1)'(1);
                    if (abort || abort_q)            state_d = StIdle;
                    else if (cnt_q == (XW+1)'(1))   state_d = StDone;
                    else                             state_d = StWait;
                end
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        cyc_d = (state_d == StBus);
        we_d  = (state_d == StBus) && !dir_d;
    end

    always_comb begin
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StDone);
        err_o          = (state_q == StFail);
        sel_ena_o      = (state_q == StWait) || (state_q == StLoad) || (state_q == StBus);
        rd_en_o        = (state_q == StWait) && !dir_q && !rd_empty_i && !abort;
        wr_en_o        = beat_ack && dir_q;
        wr_data_o      = wr_en_o ? wbm_dat_i : 32'd0;
        wbm_cyc_o      = cyc_q;
        wbm_stb_o      = cyc_q;
        wbm_we_o       = we_q;
        wbm_adr_o      = adr_q;
        wbm_dat_o      = dat_q;
        sel_base_adr_o = sel_base_q;
        sel_xfersize_o = sel_size_q;
    end

endmodule

// File: tb/tb_sd_wb_dma_master.sv
// Scoreboard bench for sd_wb_dma_master: directed transfers against a Wishbone slave and
// FIFO model, with expected beats, FIFO writes and status pulses queued up front.
module tb_sd_wb_dma_master;

    localparam int unsigned XW = 28;

    logic          wb_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   base_adr_i = '0;
    logic [XW-1:0] xfersize_i = '0;
    logic [31:0]   sel_base_adr_o;
    logic [XW-1:0] sel_xfersize_o;
    logic          sel_ena_o;
    logic [31:0]   wbm_adr_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0]   wbm_dat_o;
    logic [31:0]   wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;
    logic [31:0]   rd_data_i = '0;
    logic          rd_empty_i = 1'b1;
    logic          rd_en_o;
    logic [31:0]   wr_data_o;
    logic          wr_full_i = 1'b0;
    logic          wr_en_o;
    logic          busy_o, done_o, err_o;

    sd_wb_dma_master #(.BLKSIZE_W(12), .BLKCNT_W(16), .XW(XW)) dut (
        .wb_clk(wb_clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
        .base_adr_i(base_adr_i), .xfersize_i(xfersize_i),
        .sel_base_adr_o(sel_base_adr_o), .sel_xfersize_o(sel_xfersize_o),
        .sel_ena_o(sel_ena_o), .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .rd_data_i(rd_data_i), .rd_empty_i(rd_empty_i), .rd_en_o(rd_en_o),
        .wr_data_o(wr_data_o), .wr_full_i(wr_full_i), .wr_en_o(wr_en_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 wb_clk = ~wb_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_adr_q[$];
    logic        exp_we_q[$];
    logic [31:0] exp_bdat_q[$];
    logic [31:0] exp_wr_q[$];
    int          exp_stat_q[$];
    logic [31:0] rx_q[$];

    int ack_lat = 1;
    int err_beat = -1;
    int beat_cnt = 0;
    int stb_age = 0;
    logic force_empty = 1'b0;
    int rd_en_cnt = 0;
    int wr_cnt = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, required none", name);
    endtask

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [31:0] d);
        exp_adr_q.push_back(a);
        exp_we_q.push_back(we);
        exp_bdat_q.push_back(d);
        if (!we) exp_wr_q.push_back(mem_f(a));
    endtask

    // Wishbone slave and rx FIFO model.
    initial begin
        logic rd_en_seen;
        forever begin
            @(negedge wb_clk);
            rd_en_seen = rd_en_o;
            @(posedge wb_clk);
            #1;
            if (rd_en_seen && rx_q.size() > 0) rd_data_i = rx_q.pop_front();
            rd_empty_i = force_empty || (rx_q.size() == 0);
            if (wbm_stb_o) begin
                if (stb_age == ack_lat) begin
                    if (beat_cnt == err_beat) wbm_err_i = 1'b1;
                    else                      wbm_ack_i = 1'b1;
                    wbm_dat_i = mem_f(wbm_adr_o);
                    beat_cnt++;
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_err_i = 1'b0;
                end
                stb_age++;
            end else begin
                stb_age = 0;
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a beat, FIFO write or status.
    initial begin
        logic stb_prev;
        logic full_prev;
        stb_prev = 1'b0;
        full_prev = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (!rst) begin
                if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
                    if (exp_adr_q.size() == 0) begin
                        unexpected("bus_beat");
                    end else begin
                        logic [31:0] ea, ed;
                        logic ew;
                        ea = exp_adr_q.pop_front();
                        ew = exp_we_q.pop_front();
                        ed = exp_bdat_q.pop_front();
                        check("beat_adr", wbm_adr_o, ea);
                        check("beat_we", 32'(wbm_we_o), 32'(ew));
                        if (ew) check("beat_wdat", wbm_dat_o, ed);
                    end
                end
                if (wr_en_o) begin
                    wr_cnt++;
                    if (exp_wr_q.size() == 0) unexpected("tx_write");
                    else check("tx_data", wr_data_o, exp_wr_q.pop_front());
                end
                if (done_o || err_o) begin
                    if (exp_stat_q.size() == 0) unexpected("status_pulse");
                    else check("status_kind", done_o ? 32'd1 : 32'd2, 32'(exp_stat_q.pop_front()));
                end
                if (rd_en_o) rd_en_cnt++;
                if (wbm_stb_o && !stb_prev && !wbm_we_o) check("stb_while_full", 32'(full_prev), 0);
            end
            stb_prev = wbm_stb_o;
            full_prev = wr_full_i;
        end
    end

    task automatic do_start(input logic d, input logic [31:0] a, input logic [XW-1:0] s);
        @(posedge wb_clk);
        #1;
        dir = d;
        base_adr_i = a;
        xfersize_i = s;
        start = 1'b1;
        @(posedge wb_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
        end while (!(done_o || err_o) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done/err within 300 cycles, required one", name);
        end
    endtask

    task automatic queues_drained(input string name);
        check({name, "_beats_left"}, 32'(exp_adr_q.size()), 0);
        check({name, "_writes_left"}, 32'(exp_wr_q.size()), 0);
        check({name, "_status_left"}, 32'(exp_stat_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int n;
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_cyc", 32'(wbm_cyc_o), 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_sel_base", sel_base_adr_o, 0);
        check("rst_sel_ena", 32'(sel_ena_o), 0);
        check("rst_done_err", 32'({done_o, err_o, rd_en_o, wr_en_o}), 0);
        rst = 1'b0;

        // Memory to card, 2 words, ack one cycle after stb.
        ack_lat = 1; err_beat = -1; beat_cnt = 0;
        push_beat(32'h100, 1'b0, 0);
        push_beat(32'h104, 1'b0, 0);
        exp_stat_q.push_back(1);
        do_start(1'b1, 32'h100, 8);
        wait_end("t1");
        @(negedge wb_clk);
        check("t1_busy_after_done", 32'(busy_o), 0);
        check("t1_done_once", 32'(done_o), 0);
        check("t1_sel_base", sel_base_adr_o, 32'h100);
        check("t1_sel_size", 32'(sel_xfersize_o), 8);
        queues_drained("t1");

        // Card to memory, misaligned base gives 3 words.
        ack_lat = 0; rd_en_cnt = 0;
        rx_q.push_back(32'hCAFE0001);
        rx_q.push_back(32'hCAFE0002);
        rx_q.push_back(32'hCAFE0003);
        push_beat(32'h100, 1'b1, 32'hCAFE0001);
        push_beat(32'h104, 1'b1, 32'hCAFE0002);
        push_beat(32'h108, 1'b1, 32'hCAFE0003);
        exp_stat_q.push_back(1);
        do_start(1'b0, 32'h101, 8);
        wait_end("t2");
        check("t2_rd_en_pulses", 32'(rd_en_cnt), 3);
        queues_drained("t2");

        // Zero-length transfer.
        exp_stat_q.push_back(1);
        do_start(1'b1, 32'h200, 0);
        @(negedge wb_clk);
        check("t3_setup_no_done", 32'(done_o), 0);
        check("t3_setup_ena", 32'(sel_ena_o), 0);
        @(negedge wb_clk);
        check("t3_done", 32'(done_o), 1);
        check("t3_done_ena", 32'(sel_ena_o), 0);
        @(negedge wb_clk);
        queues_drained("t3");

        // Error on the second beat.
        ack_lat = 1; err_beat = 1; beat_cnt = 0; wr0 = wr_cnt;
        push_beat(32'h0, 1'b0, 0);
        exp_adr_q.push_back(32'h4);
        exp_we_q.push_back(1'b0);
        exp_bdat_q.push_back(0);
        exp_stat_q.push_back(2);
        do_start(1'b1, 32'h0, 12);
        wait_end("t4");
        check("t4_err", 32'(err_o), 1);
        check("t4_last_adr", wbm_adr_o, 32'h4);
        repeat (3) @(negedge wb_clk);
        check("t4_wr_count", 32'(wr_cnt - wr0), 1);
        queues_drained("t4");

        // tx FIFO full for 5 cycles after the first beat.
        ack_lat = 1; err_beat = -1; beat_cnt = 0;
        push_beat(32'h300, 1'b0, 0);
        push_beat(32'h304, 1'b0, 0);
        push_beat(32'h308, 1'b0, 0);
        exp_stat_q.push_back(1);
        do_start(1'b1, 32'h300, 12);
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
        end while (!(wbm_stb_o && wbm_ack_i) && n < 100);
        check("t5_first_ack_seen", 32'(n < 100), 1);
        @(posedge wb_clk);
        #2;
        wr_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk);
            check("t5_stb_low_while_full", 32'(wbm_stb_o), 0);
            @(posedge wb_clk);
            #2;
        end
        wr_full_i = 1'b0;
        wait_end("t5");
        queues_drained("t5");

        // Abort while waiting on an empty rx FIFO; a second start while busy is ignored.
        force_empty = 1'b1;
        do_start(1'b0, 32'h400, 4);
        @(posedge wb_clk);
        #1;
        base_adr_i = 32'h999;
        xfersize_i = 99;
        start = 1'b1;
        @(posedge wb_clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(negedge wb_clk);
        check("t6_busy_in_wait", 32'(busy_o), 1);
        @(posedge wb_clk);
        #1;
        abort = 1'b0;
        @(negedge wb_clk);
        check("t6_idle_after_abort", 32'(busy_o), 0);
        check("t6_no_status", 32'({done_o, err_o}), 0);
        check("t6_sel_base_kept", sel_base_adr_o, 32'h400);
        check("t6_sel_size_kept", 32'(sel_xfersize_o), 4);
        repeat (3) @(negedge wb_clk);
        force_empty = 1'b0;
        queues_drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
